tile_config_sequencer: RTL and testbench

- Sequences configuration writes into one PE tile.
- Accepts 32-bit addr/data writes over a valid/ready handshake and checks the tile field against the tile's tile_id.
- Decodes config_id and issues a one-cycle config-enable strobe with stable data to exactly one target: logic block, switch box, cb0 or cb1.
- Replaces the per-target address matchers in pe_tile_top. Tracks which targets are configured and counts bad writes.

---
 rtl/tile_config_sequencer_if.sv | 25 ++
 rtl/tile_config_sequencer.sv | 138 +++++++++++++
 tb/tb_tile_config_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_config_sequencer_if.sv
// Config write bus into a PE tile: valid/ready handshake carrying a 32-bit address and payload.
`default_nettype none

interface tile_config_sequencer_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] config_addr;
    logic [31:0] config_data;

    modport master (
        output cfg_valid,
        output config_addr,
        output config_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  config_addr,
        input  config_data,
        output cfg_ready
    );
endinterface

`default_nettype wire

// File: rtl/tile_config_sequencer.sv
// ----------------------------------------------------------------------------
// tile_config_sequencer
//   Checks tile id of incoming config writes, strobes one target enable,
//   holds the payload, and tracks configured targets and bad-write count.
//   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tile_config_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 8
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    tile_config_sequencer_if.slave    cfg_bus,
    input  wire logic [15:0]          tile_id,
    output logic                      config_en_logic_block,
    output logic                      config_en_sb,
    output logic                      config_en_cb0,
    output logic                      config_en_cb1,
    output logic [31:0]               config_data_out,
    output logic                      cfg_done,
    output logic                      cfg_error,
    output logic [3:0]                configured,
    output logic [ERR_CNT_W-1:0]      err_count
);

    localparam bit HAS_SETTLE = (SETTLE_CYCLES > 0);
    localparam int CNT_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CNT_LOAD   = HAS_SETTLE ? (SETTLE_CYCLES - 1) : 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_WRITE  = 3'd2,
        S_SETTLE = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [31:0]            addr_q;
    logic [31:0]            data_q;
    logic [31:0]            dout_q;
    logic [3:0]             configured_q;
    logic [ERR_CNT_W-1:0]   err_cnt_q;

    logic                   ready;
    logic                   accept;
    logic                   tile_match;
    logic                   id_valid;
    logic [3:0]             target_onehot;
    logic [3:0]             en_vec;

    assign ready  = (state_q == S_IDLE) && !reset;
    assign accept = cfg_bus.cfg_valid && ready;
    assign cfg_bus.cfg_ready = ready;

    // 16'hFFFF addresses every tile at once
    assign tile_match    = (addr_q[31:16] == tile_id) || (addr_q[31:16] == 16'hFFFF);
    assign id_valid      = (addr_q[15:2] == 14'd0);
    assign target_onehot = 4'b0001 << addr_q[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (!tile_match)    state_d = S_IDLE;
                else if (!id_valid) state_d = S_ERR;
                else                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (HAS_SETTLE) begin
                    state_d = S_SETTLE;
                    cnt_d   = CNT_W'(CNT_LOAD);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            dout_q       <= '0;
            configured_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q <= cfg_bus.config_addr;
                data_q <= cfg_bus.config_data;
            end
            if ((state_q == S_CHECK) && (state_d == S_WRITE)) begin
                dout_q <= data_q;
            end
            // Flag lands together with the done pulse
            if (state_d == S_DONE) begin
                configured_q <= configured_q | target_onehot;
            end
            if ((state_d == S_ERR) && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    assign en_vec = (state_q == S_WRITE) ? target_onehot : 4'b0000;

    assign config_en_logic_block = en_vec[0];
    assign config_en_sb          = en_vec[1];
    assign config_en_cb0         = en_vec[2];
    assign config_en_cb1         = en_vec[3];
    assign config_data_out       = dout_q;
    assign cfg_done              = (state_q == S_DONE);
    assign cfg_error             = (state_q == S_ERR);
    assign configured            = configured_q;
    assign err_count             = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_tile_config_sequencer.sv
// Self-checking bench: table of single writes plus hand-written sequences for saturation,
// back-to-back, mid-write reset and a zero-settle build.
`default_nettype none

module tb_tile_config_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tile_config_sequencer_if bus ();
    tile_config_sequencer_if bus0 ();

    logic        en_lb, en_sb, en_cb0, en_cb1, done, err;
    logic [31:0] dout;
    logic [3:0]  cfg;
    logic [7:0]  ecnt;
    logic        en_lb0, en_sb0, en_cb00, en_cb10, done0, err0;
    logic [31:0] dout0;
    logic [3:0]  cfg0;
    logic [7:0]  ecnt0;

    tile_config_sequencer #(.SETTLE_CYCLES(2), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_bus(bus.slave), .tile_id(16'h0001),
        .config_en_logic_block(en_lb), .config_en_sb(en_sb),
        .config_en_cb0(en_cb0), .config_en_cb1(en_cb1),
        .config_data_out(dout), .cfg_done(done), .cfg_error(err),
        .configured(cfg), .err_count(ecnt)
    );

    tile_config_sequencer #(.SETTLE_CYCLES(0), .ERR_CNT_W(8)) dut_s0 (
        .clk(clk), .reset(reset), .cfg_bus(bus0.slave), .tile_id(16'h0001),
        .config_en_logic_block(en_lb0), .config_en_sb(en_sb0),
        .config_en_cb0(en_cb00), .config_en_cb1(en_cb10),
        .config_data_out(dout0), .cfg_done(done0), .cfg_error(err0),
        .configured(cfg0), .err_count(ecnt0)
    );

    typedef struct {
        logic [3:0]  en;
        logic        done;
        logic        err;
        logic        ready;
        logic [31:0] dout;
        logic [3:0]  cfg;
        logic [7:0]  ecnt;
    } obs_t;

    typedef struct {
        int          en_cyc;
        int          en_cnt;
        int          done_cyc;
        int          err_cyc;
        int          rdy_cyc;
        int          bad;
        logic [3:0]  en_val;
        logic [31:0] dout_en;
        logic [31:0] dout_done;
    } res_t;

    localparam int K_MATCH = 0;
    localparam int K_MISS  = 1;
    localparam int K_ERR   = 2;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          kind;
        logic [3:0]  en;
        logic [3:0]  cfg;
        logic [7:0]  ecnt;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic obs_t sample(input int sel);
        obs_t o;
        if (sel == 0) begin
            o.en = {en_cb1, en_cb0, en_sb, en_lb};
            o.done = done; o.err = err; o.ready = bus.cfg_ready;
            o.dout = dout; o.cfg = cfg; o.ecnt = ecnt;
        end else begin
            o.en = {en_cb10, en_cb00, en_sb0, en_lb0};
            o.done = done0; o.err = err0; o.ready = bus0.cfg_ready;
            o.dout = dout0; o.cfg = cfg0; o.ecnt = ecnt0;
        end
        return o;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus.cfg_valid = v; bus.config_addr = a; bus.config_data = d;
        end else begin
            bus0.cfg_valid = v; bus0.config_addr = a; bus0.config_data = d;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left at posedge+1; cycle numbers are relative to the accept cycle
    task automatic run_write(input int sel, input logic [31:0] a, input logic [31:0] d,
                             output res_t r);
        obs_t o;
        int   k;
        r = '{en_cyc: -1, en_cnt: 0, done_cyc: -1, err_cyc: -1, rdy_cyc: -1,
               bad: 0, en_val: 4'h0, dout_en: 32'h0, dout_done: 32'h0};
        k = 0;
        while (!sample(sel).ready && k < 20) begin
            tick();
            k++;
        end
        if (k >= 20) chk("ready_wait_timeout", 64'(k), 64'(0));
        drive(sel, 1'b1, a, d);
        tick();
        drive(sel, 1'b0, 32'h0, 32'h0);
        for (int c = 1; c <= 12; c++) begin
            o = sample(sel);
            if (o.en != 4'h0) begin
                r.en_cnt++;
                if (r.en_cyc < 0) begin
                    r.en_cyc  = c;
                    r.en_val  = o.en;
                    r.dout_en = o.dout;
                end
            end
            if ($countones(o.en) > 1 || (o.done && o.err)) r.bad++;
            if (o.done && r.done_cyc < 0) begin
                r.done_cyc  = c;
                r.dout_done = o.dout;
            end
            if (o.err && r.err_cyc < 0) r.err_cyc = c;
            if (o.ready) begin
                r.rdy_cyc = c;
                break;
            end
            tick();
        end
    endtask

    vec_t        vecs [8];
    res_t        r;
    obs_t        o;
    logic [31:0] exp_dout;
    int          ev_cyc [8];
    logic [3:0]  ev_val [8];
    int          n_ev, overlap, idx, cyc;
    logic        acc;

    initial begin
        vecs[0] = '{32'h0001_0002, 32'hDEADBEEF, K_MATCH, 4'b0100, 4'b0100, 8'd0};
        vecs[1] = '{32'h0005_0001, 32'h12345678, K_MISS,  4'b0000, 4'b0100, 8'd0};
        vecs[2] = '{32'hFFFF_0001, 32'hCAFEF00D, K_MATCH, 4'b0010, 4'b0110, 8'd0};
        vecs[3] = '{32'h0001_0009, 32'h00000000, K_ERR,   4'b0000, 4'b0110, 8'd1};
        vecs[4] = '{32'h0001_0000, 32'h11111111, K_MATCH, 4'b0001, 4'b0111, 8'd1};
        vecs[5] = '{32'h0001_0002, 32'hA5A5A5A5, K_MATCH, 4'b0100, 4'b0111, 8'd1};
        vecs[6] = '{32'h0001_0100, 32'h55555555, K_ERR,   4'b0000, 4'b0111, 8'd2};
        vecs[7] = '{32'h0002_0003, 32'h77777777, K_MISS,  4'b0000, 4'b0111, 8'd2};

        reset = 1'b1;
        drive(0, 1'b1, 32'h0001_0000, 32'h1);
        drive(1, 1'b0, 32'h0, 32'h0);
        tick(); tick();
        o = sample(0);
        chk("reset_ready_low", 64'(o.ready), 64'(0));
        chk("reset_en", 64'(o.en), 64'(0));
        chk("reset_dout", 64'(o.dout), 64'(0));
        chk("reset_flags", 64'({o.done, o.err, o.cfg, o.ecnt}), 64'(0));
        chk("reset_ready_low_s0", 64'(sample(1).ready), 64'(0));
        drive(0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        tick();
        chk("ready_after_reset", 64'(sample(0).ready), 64'(1));

        exp_dout = 32'h0;
        foreach (vecs[i]) begin
            run_write(0, vecs[i].addr, vecs[i].data, r);
            if (vecs[i].kind == K_MATCH) exp_dout = vecs[i].data;
            chk($sformatf("v%0d_en_cyc", i),   64'(r.en_cyc),
                64'(vecs[i].kind == K_MATCH ? 2 : -1));
            chk($sformatf("v%0d_en_val", i),   64'(r.en_val), 64'(vecs[i].en));
            chk($sformatf("v%0d_en_cnt", i),   64'(r.en_cnt),
                64'(vecs[i].kind == K_MATCH ? 1 : 0));
            chk($sformatf("v%0d_done_cyc", i), 64'(r.done_cyc),
                64'(vecs[i].kind == K_MATCH ? 5 : -1));
            chk($sformatf("v%0d_err_cyc", i),  64'(r.err_cyc),
                64'(vecs[i].kind == K_ERR ? 2 : -1));
            chk($sformatf("v%0d_rdy_cyc", i),  64'(r.rdy_cyc),
                64'(vecs[i].kind == K_MATCH ? 6 : (vecs[i].kind == K_ERR ? 3 : 2)));
            chk($sformatf("v%0d_bad", i),      64'(r.bad), 64'(0));
            if (vecs[i].kind == K_MATCH) begin
                chk($sformatf("v%0d_dout_en", i),   64'(r.dout_en),   64'(vecs[i].data));
                chk($sformatf("v%0d_dout_done", i), 64'(r.dout_done), 64'(vecs[i].data));
            end
            o = sample(0);
            chk($sformatf("v%0d_dout_hold", i), 64'(o.dout), 64'(exp_dout));
            chk($sformatf("v%0d_configured", i), 64'(o.cfg), 64'(vecs[i].cfg));
            chk($sformatf("v%0d_err_count", i),  64'(o.ecnt), 64'(vecs[i].ecnt));
        end

        // Error counter saturates at 255
        overlap = 0;
        for (int i = 0; i < 300; i++) begin
            run_write(0, 32'h0001_0009, 32'h0, r);
            if (r.err_cyc != 2 || r.en_cnt != 0 || r.done_cyc != -1) overlap++;
        end
        chk("sat_each_err_ok", 64'(overlap), 64'(0));
        o = sample(0);
        chk("sat_err_count", 64'(o.ecnt), 64'(255));
        chk("sat_configured", 64'(o.cfg), 64'(4'b0111));

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("rst2_configured", 64'(sample(0).cfg), 64'(0));

        // Back-to-back writes with valid held high
        n_ev = 0; overlap = 0; idx = 0;
        drive(0, 1'b1, 32'h0001_0000, 32'h1000_0000);
        for (cyc = 0; cyc < 40; cyc++) begin
            o = sample(0);
            if (o.en != 4'h0 && n_ev < 8) begin
                ev_cyc[n_ev] = cyc;
                ev_val[n_ev] = o.en;
                n_ev++;
            end
            if ($countones(o.en) > 1 || (o.done && o.err)) overlap++;
            acc = o.ready && bus.cfg_valid;
            tick();
            if (acc) begin
                idx++;
                if (idx < 4) drive(0, 1'b1, 32'h0001_0000 | 32'(idx), 32'h1000_0000 + 32'(idx));
                else         drive(0, 1'b0, 32'h0, 32'h0);
            end
        end
        chk("b2b_num_enables", 64'(n_ev), 64'(4));
        chk("b2b_overlap", 64'(overlap), 64'(0));
        for (int i = 0; i < 4; i++) begin
            if (i < n_ev) begin
                chk($sformatf("b2b_en%0d_val", i), 64'(ev_val[i]), 64'(4'b0001 << i));
                if (i > 0) chk($sformatf("b2b_en%0d_gap", i),
                               64'(ev_cyc[i] - ev_cyc[i-1]), 64'(6));
            end
        end
        chk("b2b_first_en_cyc", 64'(n_ev > 0 ? ev_cyc[0] : -1), 64'(2));
        o = sample(0);
        chk("b2b_configured", 64'(o.cfg), 64'(4'b1111));
        chk("b2b_dout_last", 64'(o.dout), 64'(32'h1000_0003));

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Reset lands during SETTLE of a write to id 3
        drive(0, 1'b1, 32'h0001_0003, 32'hBADC0FFE);
        tick();
        drive(0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("mid_en_cb1_at_write", 64'(sample(0).en), 64'(4'b1000));
        tick();
        reset = 1'b1;
        tick();
        o = sample(0);
        chk("mid_rst_en", 64'(o.en), 64'(0));
        chk("mid_rst_dout", 64'(o.dout), 64'(0));
        chk("mid_rst_done_err", 64'({o.done, o.err}), 64'(0));
        chk("mid_rst_configured", 64'(o.cfg), 64'(0));
        chk("mid_rst_ready", 64'(o.ready), 64'(0));
        reset = 1'b0;
        overlap = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (sample(0).done || sample(0).en != 4'h0) overlap++;
        end
        chk("mid_no_late_done", 64'(overlap), 64'(0));
        run_write(0, 32'h0001_0003, 32'h0BADF00D, r);
        chk("mid_rewrite_en", 64'(r.en_val), 64'(4'b1000));
        chk("mid_rewrite_done_cyc", 64'(r.done_cyc), 64'(5));
        chk("mid_rewrite_configured", 64'(sample(0).cfg), 64'(4'b1000));
        chk("mid_rewrite_dout", 64'(sample(0).dout), 64'(32'h0BADF00D));

        // Zero-settle build
        run_write(1, 32'h0001_0000, 32'h600DCAFE, r);
        chk("s0_en_cyc", 64'(r.en_cyc), 64'(2));
        chk("s0_en_val", 64'(r.en_val), 64'(4'b0001));
        chk("s0_done_cyc", 64'(r.done_cyc), 64'(3));
        chk("s0_rdy_cyc", 64'(r.rdy_cyc), 64'(4));
        chk("s0_dout", 64'(r.dout_en), 64'(32'h600DCAFE));
        chk("s0_configured", 64'(sample(1).cfg), 64'(4'b0001));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
